pol_fm_fetch: RTL and testbench

Feature-map fetch responder on the pooling (POL) side. It accepts the gather addresses that the pooling logic core issues over its address valid/ready channel, and issues in-order reads to the global buffer (GLB). It returns the addressed feature-map rows, POOL_COMP_CORE channels wide, over the Fm valid/ready channel. Because GLB read data cannot be back-pressured, a credit scheme guarantees the output FIFO never overflows.

---
 rtl/pol_fm_fetch.sv | 143 ++++++++++++++
 tb/tb_pol_fm_fetch.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pol_fm_fetch.sv
// pol_fm_fetch: feature-map fetch responder for the pooling side.
// Accepts gather addresses, issues in-order GLB row reads and returns the
// rows through a first-word fall-through FIFO. GLB read data cannot be
// stalled, so requests are only issued while FIFO space is reserved for them.
// Optional feature: define POL_FETCH_BASE_EN to add a CfgBaseAddr offset
// to every GLB row address (wrapping modulo 2**IDX_WIDTH).
module pol_fm_fetch #(
  parameter int IDX_WIDTH        = 10,
  parameter int ACT_WIDTH        = 8,
  parameter int POOL_COMP_CORE   = 64,
  parameter int FIFO_DEPTH_WIDTH = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
`ifdef POL_FETCH_BASE_EN
  input  logic [IDX_WIDTH-1:0]                CfgBaseAddr,
`endif
  input  logic                                PLCPOL_AddrVld,
  input  logic [IDX_WIDTH-1:0]                PLCPOL_Addr,
  output logic                                POLPLC_AddrRdy,
  output logic                                POLGLB_RdAddrVld,
  output logic [IDX_WIDTH-1:0]                POLGLB_RdAddr,
  input  logic                                GLBPOL_RdAddrRdy,
  input  logic                                GLBPOL_RdDatVld,
  input  logic [ACT_WIDTH*POOL_COMP_CORE-1:0] GLBPOL_RdDat,
  output logic [ACT_WIDTH*POOL_COMP_CORE-1:0] POLPLC_Fm,
  output logic                                POLPLC_FmVld,
  input  logic                                PLCPOL_FmRdy,
  output logic                                POLFETCH_Idle,
  output logic                                POLFETCH_Err
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_WIDTH;
  localparam int ROW_W = ACT_WIDTH * POOL_COMP_CORE;
  localparam int CNT_W = FIFO_DEPTH_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic                        addrVld_q, addrVld_d;
  logic [IDX_WIDTH-1:0]        addrReg_q, addrReg_d;
  logic [CNT_W-1:0]            inflight_q, inflight_d;
  logic [CNT_W-1:0]            fifoCount_q, fifoCount_d;
  logic [FIFO_DEPTH_WIDTH-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_DEPTH_WIDTH-1:0] rdPtr_q, rdPtr_d;
  logic                        err_q, err_d;
  logic [ROW_W-1:0]            mem_q [DEPTH];

  logic [CNT_W-1:0] credit;
  logic             addrLoad;
  logic             reqFire;
  logic             datAccept;
  logic             datSpurious;
  logic             pop;

  // Every issued request and every buffered row holds one FIFO slot; the
  // remainder is what may still be requested.
  assign credit           = DEPTH_C - fifoCount_q - inflight_q;
  assign POLGLB_RdAddrVld = addrVld_q & (credit != '0);
  assign reqFire          = POLGLB_RdAddrVld & GLBPOL_RdAddrRdy;
  assign POLPLC_AddrRdy   = ~addrVld_q | reqFire;
  assign addrLoad         = PLCPOL_AddrVld & POLPLC_AddrRdy;

`ifdef POL_FETCH_BASE_EN
  assign POLGLB_RdAddr = addrReg_q + CfgBaseAddr;
`else
  assign POLGLB_RdAddr = addrReg_q;
`endif

  // Data with nothing outstanding cannot belong to any request: drop it.
  assign datAccept   = GLBPOL_RdDatVld & (inflight_q != '0);
  assign datSpurious = GLBPOL_RdDatVld & (inflight_q == '0);

  assign POLPLC_FmVld  = (fifoCount_q != '0);
  assign pop           = POLPLC_FmVld & PLCPOL_FmRdy;
  assign POLPLC_Fm     = POLPLC_FmVld ? mem_q[rdPtr_q] : '0;
  assign POLFETCH_Idle = ~addrVld_q & (inflight_q == '0) & (fifoCount_q == '0);
  assign POLFETCH_Err  = err_q;

  // Next-state for the address register, counters, pointers and error flag.
  always_comb begin
    addrVld_d   = addrVld_q;
    addrReg_d   = addrReg_q;
    inflight_d  = inflight_q;
    fifoCount_d = fifoCount_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    err_d       = err_q | datSpurious;

    if (addrLoad) begin
      addrVld_d = 1'b1;
      addrReg_d = PLCPOL_Addr;
    end else if (reqFire) begin
      addrVld_d = 1'b0;
    end

    case ({reqFire, datAccept})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    case ({datAccept, pop})
      2'b10:   fifoCount_d = fifoCount_q + 1'b1;
      2'b01:   fifoCount_d = fifoCount_q - 1'b1;
      default: fifoCount_d = fifoCount_q;
    endcase

    if (datAccept) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
  end

  // Control state registers; reset drops everything in flight at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrVld_q   <= 1'b0;
      addrReg_q   <= '0;
      inflight_q  <= '0;
      fifoCount_q <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      addrVld_q   <= addrVld_d;
      addrReg_q   <= addrReg_d;
      inflight_q  <= inflight_d;
      fifoCount_q <= fifoCount_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      err_q       <= err_d;
    end
  end

  // Row storage; contents are only observed through the count-gated head.
  always_ff @(posedge clk) begin
    if (datAccept) begin
      mem_q[wrPtr_q] <= GLBPOL_RdDat;
    end
  end

endmodule

// File: tb/tb_pol_fm_fetch.sv
// tb_pol_fm_fetch: randomized self-checking bench for pol_fm_fetch with a
// behavioural GLB and an order-preserving reference of accepted addresses.
module tb_pol_fm_fetch;

  localparam int IDX_W = 10;
  localparam int ROW_W = 512;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              PLCPOL_AddrVld;
  logic [IDX_W-1:0]  PLCPOL_Addr;
  logic              POLPLC_AddrRdy;
  logic              POLGLB_RdAddrVld;
  logic [IDX_W-1:0]  POLGLB_RdAddr;
  logic              GLBPOL_RdAddrRdy = 1'b1;
  logic              GLBPOL_RdDatVld = 1'b0;
  logic [ROW_W-1:0]  GLBPOL_RdDat = '0;
  logic [ROW_W-1:0]  POLPLC_Fm;
  logic              POLPLC_FmVld;
  logic              PLCPOL_FmRdy = 1'b0;
  logic              POLFETCH_Idle;
  logic              POLFETCH_Err;
`ifdef POL_FETCH_BASE_EN
  logic [IDX_W-1:0]  CfgBaseAddr;
`endif

  int assertCount = 0;
  int failCount = 0;
  int cyc = 0;
  int base = 0;

  bit glbStall = 0, glbRandom = 0, fmRandom = 0, injectSpurious = 0, fmRdyBase = 0;
  int latMin = 1, latMax = 1, lastDue = 0, dueTmp;
  int issued = 0, popped = 0, maxOutstanding = 0;

  logic [IDX_W-1:0] glbAddrQ[$];
  int               glbDueQ[$];
  logic [IDX_W-1:0] accQ[$];
  logic [IDX_W-1:0] reqQ[$];
  int               accCyc[$];
  int               popCyc[$];
  logic [ROW_W-1:0] rowQ[$];

  pol_fm_fetch dut (
    .clk              (clk),
    .rst_n            (rst_n),
`ifdef POL_FETCH_BASE_EN
    .CfgBaseAddr      (CfgBaseAddr),
`endif
    .PLCPOL_AddrVld   (PLCPOL_AddrVld),
    .PLCPOL_Addr      (PLCPOL_Addr),
    .POLPLC_AddrRdy   (POLPLC_AddrRdy),
    .POLGLB_RdAddrVld (POLGLB_RdAddrVld),
    .POLGLB_RdAddr    (POLGLB_RdAddr),
    .GLBPOL_RdAddrRdy (GLBPOL_RdAddrRdy),
    .GLBPOL_RdDatVld  (GLBPOL_RdDatVld),
    .GLBPOL_RdDat     (GLBPOL_RdDat),
    .POLPLC_Fm        (POLPLC_Fm),
    .POLPLC_FmVld     (POLPLC_FmVld),
    .PLCPOL_FmRdy     (PLCPOL_FmRdy),
    .POLFETCH_Idle    (POLFETCH_Idle),
    .POLFETCH_Err     (POLFETCH_Err)
  );

  always #5 clk = ~clk;

  // Content the GLB holds at each row address.
  function automatic logic [ROW_W-1:0] rowOf(input logic [IDX_W-1:0] a);
    logic [ROW_W-1:0] r;
    for (int i = 0; i < 16; i++)
      r[i*32 +: 32] = (32'(a) + 32'd1) * 32'h9E3779B1 + 32'(i) * 32'h01010101;
    return r;
  endfunction

  // Row address the GLB should see for a gather address.
  function automatic logic [IDX_W-1:0] mapAddr(input logic [IDX_W-1:0] a);
    return IDX_W'((int'(a) + base) % 1024);
  endfunction

  // GLB model and handshake logger: drives at negedge+2, samples at negedge+3.
  always begin
    @(negedge clk);
    cyc++;
    #2;
    if (injectSpurious) begin
      GLBPOL_RdDatVld = 1'b1;
      GLBPOL_RdDat    = {16{$urandom()}};
    end else if (glbDueQ.size() > 0 && glbDueQ[0] == cyc) begin
      GLBPOL_RdDatVld = 1'b1;
      GLBPOL_RdDat    = rowOf(glbAddrQ.pop_front());
      void'(glbDueQ.pop_front());
    end else begin
      GLBPOL_RdDatVld = 1'b0;
      GLBPOL_RdDat    = '0;
    end
    GLBPOL_RdAddrRdy = glbStall ? 1'b0 : (glbRandom ? 1'($urandom_range(0, 1)) : 1'b1);
    PLCPOL_FmRdy     = fmRandom ? 1'($urandom_range(0, 1)) : fmRdyBase;
    #1;
    if (rst_n !== 1'b1) begin
      glbAddrQ.delete();
      glbDueQ.delete();
      lastDue = cyc;
      popped  = issued;
    end else begin
      if (PLCPOL_AddrVld === 1'b1 && POLPLC_AddrRdy === 1'b1) begin
        accQ.push_back(PLCPOL_Addr);
        accCyc.push_back(cyc);
      end
      if (POLGLB_RdAddrVld === 1'b1 && GLBPOL_RdAddrRdy === 1'b1) begin
        dueTmp = cyc + $urandom_range(latMax, latMin);
        if (dueTmp <= lastDue) dueTmp = lastDue + 1;
        lastDue = dueTmp;
        reqQ.push_back(POLGLB_RdAddr);
        glbAddrQ.push_back(POLGLB_RdAddr);
        glbDueQ.push_back(dueTmp);
        issued++;
      end
      if (POLPLC_FmVld === 1'b1 && PLCPOL_FmRdy === 1'b1) begin
        rowQ.push_back(POLPLC_Fm);
        popCyc.push_back(cyc);
        popped++;
      end
      if (issued - popped > maxOutstanding) maxOutstanding = issued - popped;
    end
  end

  // Offer one address (call at a negedge); returns at the negedge after acceptance.
  task automatic pushAddr(input logic [IDX_W-1:0] a, input int budget, output bit ok);
    ok = 0;
    PLCPOL_AddrVld = 1'b1;
    PLCPOL_Addr    = a;
    for (int k = 0; k < budget && !ok; k++) begin
      #4;
      if (POLPLC_AddrRdy === 1'b1) ok = 1;
      @(negedge clk);
    end
  endtask

  task automatic waitRows(input int target, input int budget, output bit ok);
    for (int k = 0; k < budget && rowQ.size() < target; k++) @(negedge clk);
    ok = (rowQ.size() >= target);
  endtask

  task automatic test_reset;
    @(negedge clk); #3;
    assertCount++; if (POLPLC_AddrRdy !== 1'b1) begin failCount++; $display("[TB] FAIL reset_addr_rdy got %b exp 1", POLPLC_AddrRdy); end
    assertCount++; if (POLGLB_RdAddrVld !== 1'b0) begin failCount++; $display("[TB] FAIL reset_rd_vld got %b exp 0", POLGLB_RdAddrVld); end
    assertCount++; if (POLGLB_RdAddr !== 10'd0) begin failCount++; $display("[TB] FAIL reset_rd_addr got %0d exp 0", POLGLB_RdAddr); end
    assertCount++; if (POLPLC_FmVld !== 1'b0) begin failCount++; $display("[TB] FAIL reset_fm_vld got %b exp 0", POLPLC_FmVld); end
    assertCount++; if (POLPLC_Fm !== '0) begin failCount++; $display("[TB] FAIL reset_fm got nonzero exp 0"); end
    assertCount++; if (POLFETCH_Idle !== 1'b1) begin failCount++; $display("[TB] FAIL reset_idle got %b exp 1", POLFETCH_Idle); end
    assertCount++; if (POLFETCH_Err !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err got %b exp 0", POLFETCH_Err); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); #3;
    assertCount++; if (POLFETCH_Idle !== 1'b1 || POLPLC_AddrRdy !== 1'b1) begin failCount++; $display("[TB] FAIL post_reset_idle got idle=%b rdy=%b exp 1/1", POLFETCH_Idle, POLPLC_AddrRdy); end
  endtask

  task automatic test_streaming;
    int a0, r0, q0, bad;
    bit ok, allOk;
    @(negedge clk);
    fmRdyBase = 1; latMin = 1; latMax = 1;
    a0 = accQ.size(); r0 = rowQ.size(); q0 = reqQ.size();
    allOk = 1;
    for (int i = 0; i < 8; i++) begin pushAddr(IDX_W'(i), 20, ok); allOk &= ok; end
    PLCPOL_AddrVld = 1'b0;
    waitRows(r0 + 8, 60, ok);
    allOk &= ok;
    assertCount++; if (!allOk) begin failCount++; $display("[TB] FAIL stream_complete got rows=%0d exp 8", rowQ.size() - r0); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (r0 + i >= rowQ.size() || rowQ[r0+i] !== rowOf(mapAddr(IDX_W'(i)))) bad++;
      if (q0 + i >= reqQ.size() || reqQ[q0+i] !== mapAddr(IDX_W'(i))) bad++;
    end
    assertCount++; if (bad !== 0) begin failCount++; $display("[TB] FAIL stream_order got %0d bad entries exp 0", bad); end
    if (allOk) begin
      assertCount++; if (popCyc[r0] - accCyc[a0] !== 3) begin failCount++; $display("[TB] FAIL stream_latency got %0d exp 3", popCyc[r0] - accCyc[a0]); end
      assertCount++; if (popCyc[r0+7] - popCyc[r0] !== 7) begin failCount++; $display("[TB] FAIL stream_row_rate got %0d exp 7", popCyc[r0+7] - popCyc[r0]); end
      assertCount++; if (accCyc[a0+7] - accCyc[a0] !== 7) begin failCount++; $display("[TB] FAIL stream_addr_rate got %0d exp 7", accCyc[a0+7] - accCyc[a0]); end
    end
  endtask

  task automatic test_backpressure;
    int a0, r0, q0, i, bad;
    bit ok, allOk;
    @(negedge clk);
    fmRdyBase = 0; latMin = 1; latMax = 1;
    a0 = accQ.size(); r0 = rowQ.size(); q0 = reqQ.size();
    i = 0; ok = 1;
    while (i < 8 && ok) begin
      pushAddr(IDX_W'(100 + i), 12, ok);
      if (ok) i++;
    end
    #3;
    assertCount++; if (accQ.size() - a0 !== 5) begin failCount++; $display("[TB] FAIL bp_accepted got %0d exp 5", accQ.size() - a0); end
    assertCount++; if (reqQ.size() - q0 !== DEPTH) begin failCount++; $display("[TB] FAIL bp_requests got %0d exp %0d", reqQ.size() - q0, DEPTH); end
    assertCount++; if (POLPLC_AddrRdy !== 1'b0 || POLGLB_RdAddrVld !== 1'b0) begin failCount++; $display("[TB] FAIL bp_stalled got rdy=%b rdvld=%b exp 0/0", POLPLC_AddrRdy, POLGLB_RdAddrVld); end
    assertCount++; if (POLPLC_FmVld !== 1'b1 || rowQ.size() != r0) begin failCount++; $display("[TB] FAIL bp_fifo_held got vld=%b popped=%0d exp 1/0", POLPLC_FmVld, rowQ.size() - r0); end
    @(negedge clk);
    fmRdyBase = 1;
    allOk = 1;
    while (i < 8) begin pushAddr(IDX_W'(100 + i), 30, ok); allOk &= ok; i++; end
    PLCPOL_AddrVld = 1'b0;
    waitRows(r0 + 8, 80, ok);
    allOk &= ok;
    bad = 0;
    for (int k = 0; k < 8; k++)
      if (r0 + k >= rowQ.size() || rowQ[r0+k] !== rowOf(mapAddr(IDX_W'(100 + k)))) bad++;
    assertCount++; if (!allOk || bad !== 0) begin failCount++; $display("[TB] FAIL bp_drain got %0d bad rows (done=%b) exp 0", bad, allOk); end
  endtask

  task automatic test_glb_stall;
    int r0, q0, bad;
    bit ok, allOk, addrStable, rdyLow, noRows;
    logic [IDX_W-1:0] seq [3];
    seq[0] = 10'h155; seq[1] = 10'h2AA; seq[2] = 10'h0F0;
    @(negedge clk);
    fmRdyBase = 1; glbStall = 1;
    r0 = rowQ.size(); q0 = reqQ.size();
    pushAddr(seq[0], 10, allOk);
    PLCPOL_AddrVld = 1'b1; PLCPOL_Addr = seq[1];
    addrStable = 1; rdyLow = 1; noRows = 1;
    repeat (5) begin
      #3;
      if (POLGLB_RdAddr !== mapAddr(seq[0]) || POLGLB_RdAddrVld !== 1'b1) addrStable = 0;
      if (POLPLC_AddrRdy !== 1'b0) rdyLow = 0;
      if (POLPLC_FmVld !== 1'b0) noRows = 0;
      @(negedge clk);
    end
    assertCount++; if (!addrStable) begin failCount++; $display("[TB] FAIL stall_addr_hold got addr=%0d exp %0d", POLGLB_RdAddr, mapAddr(seq[0])); end
    assertCount++; if (!rdyLow) begin failCount++; $display("[TB] FAIL stall_addr_rdy got high exp low"); end
    assertCount++; if (!noRows || reqQ.size() != q0) begin failCount++; $display("[TB] FAIL stall_quiet got reqs=%0d rowsvld=%b exp 0/1", reqQ.size() - q0, noRows); end
    glbStall = 0;
    pushAddr(seq[1], 20, ok); allOk &= ok;
    pushAddr(seq[2], 20, ok); allOk &= ok;
    PLCPOL_AddrVld = 1'b0;
    waitRows(r0 + 3, 40, ok); allOk &= ok;
    bad = 0;
    for (int k = 0; k < 3; k++)
      if (r0 + k >= rowQ.size() || rowQ[r0+k] !== rowOf(mapAddr(seq[k]))) bad++;
    assertCount++; if (!allOk || bad !== 0) begin failCount++; $display("[TB] FAIL stall_resume got %0d bad rows (done=%b) exp 0", bad, allOk); end
  endtask

  task automatic test_random;
    int a0, r0, q0, badRow, badReq, badAcc;
    bit ok, allOk;
    logic [IDX_W-1:0] sent[$];
    @(negedge clk);
    glbRandom = 1; fmRandom = 1; latMin = 1; latMax = 4;
    a0 = accQ.size(); r0 = rowQ.size(); q0 = reqQ.size();
    allOk = 1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin PLCPOL_AddrVld = 1'b0; @(negedge clk); end
      sent.push_back(IDX_W'($urandom_range(0, 1023)));
      pushAddr(sent[i], 200, ok); allOk &= ok;
    end
    PLCPOL_AddrVld = 1'b0;
    waitRows(r0 + 40, 2000, ok); allOk &= ok;
    glbRandom = 0; fmRandom = 0; fmRdyBase = 1;
    badRow = 0; badReq = 0; badAcc = 0;
    for (int i = 0; i < 40; i++) begin
      if (a0 + i >= accQ.size() || accQ[a0+i] !== sent[i]) badAcc++;
      if (q0 + i >= reqQ.size() || reqQ[q0+i] !== mapAddr(sent[i])) badReq++;
      if (r0 + i >= rowQ.size() || rowQ[r0+i] !== rowOf(mapAddr(sent[i]))) badRow++;
    end
    assertCount++; if (!allOk || badAcc !== 0) begin failCount++; $display("[TB] FAIL rand_accept got %0d bad (done=%b) exp 0", badAcc, allOk); end
    assertCount++; if (badReq !== 0) begin failCount++; $display("[TB] FAIL rand_req_order got %0d bad exp 0", badReq); end
    assertCount++; if (badRow !== 0) begin failCount++; $display("[TB] FAIL rand_row_order got %0d bad exp 0", badRow); end
    assertCount++; if (maxOutstanding > DEPTH) begin failCount++; $display("[TB] FAIL rand_credit got %0d outstanding exp <=%0d", maxOutstanding, DEPTH); end
    repeat (6) @(negedge clk);
    #3;
    assertCount++; if (POLFETCH_Idle !== 1'b1 || POLFETCH_Err !== 1'b0) begin failCount++; $display("[TB] FAIL rand_idle got idle=%b err=%b exp 1/0", POLFETCH_Idle, POLFETCH_Err); end
  endtask

`ifdef POL_FETCH_BASE_EN
  task automatic test_base;
    int r0;
    bit ok;
    @(negedge clk);
    CfgBaseAddr = 10'd1020; base = 1020; fmRdyBase = 1; latMin = 1; latMax = 1;
    r0 = rowQ.size();
    pushAddr(10'd10, 10, ok);
    PLCPOL_AddrVld = 1'b0;
    #3;
    assertCount++; if (POLGLB_RdAddrVld !== 1'b1 || POLGLB_RdAddr !== 10'd6) begin failCount++; $display("[TB] FAIL base_wrap got vld=%b addr=%0d exp 1/6", POLGLB_RdAddrVld, POLGLB_RdAddr); end
    @(negedge clk);
    waitRows(r0 + 1, 20, ok);
    assertCount++; if (!ok || rowQ[r0] !== rowOf(10'd6)) begin failCount++; $display("[TB] FAIL base_row got row_for_6=%b exp 1", ok && rowQ[r0] === rowOf(10'd6)); end
    repeat (3) @(negedge clk);
    CfgBaseAddr = 10'd0; base = 0;
  endtask
`endif

  task automatic test_spurious;
    bit errHeld, fifoEmpty;
    @(negedge clk);
    injectSpurious = 1;
    @(negedge clk);
    injectSpurious = 0;
    #3;
    assertCount++; if (POLFETCH_Err !== 1'b1) begin failCount++; $display("[TB] FAIL spurious_err got %b exp 1", POLFETCH_Err); end
    errHeld = 1; fifoEmpty = 1;
    repeat (5) begin
      @(negedge clk); #3;
      if (POLFETCH_Err !== 1'b1) errHeld = 0;
      if (POLPLC_FmVld !== 1'b0 || POLFETCH_Idle !== 1'b1) fifoEmpty = 0;
    end
    assertCount++; if (!errHeld) begin failCount++; $display("[TB] FAIL spurious_sticky got cleared exp held"); end
    assertCount++; if (!fifoEmpty) begin failCount++; $display("[TB] FAIL spurious_dropped got vld=%b idle=%b exp 0/1", POLPLC_FmVld, POLFETCH_Idle); end
  endtask

  task automatic test_reset_midstream;
    int r0, bad;
    bit ok, allOk;
    @(negedge clk);
    fmRdyBase = 1; latMin = 3; latMax = 3;
    allOk = 1;
    for (int i = 0; i < 3; i++) begin pushAddr(IDX_W'(500 + i), 20, ok); allOk &= ok; end
    PLCPOL_AddrVld = 1'b0;
    #3;
    assertCount++; if (!allOk || POLFETCH_Idle !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_busy got idle=%b exp 0", POLFETCH_Idle); end
    @(negedge clk);
    rst_n = 1'b0;
    #3;
    assertCount++; if (POLPLC_FmVld !== 1'b0 || POLFETCH_Idle !== 1'b1) begin failCount++; $display("[TB] FAIL midrst_clear got vld=%b idle=%b exp 0/1", POLPLC_FmVld, POLFETCH_Idle); end
    assertCount++; if (POLPLC_AddrRdy !== 1'b1 || POLGLB_RdAddrVld !== 1'b0 || POLFETCH_Err !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_ctrl got rdy=%b rdvld=%b err=%b exp 1/0/0", POLPLC_AddrRdy, POLGLB_RdAddrVld, POLFETCH_Err); end
    @(negedge clk);
    rst_n = 1'b1;
    latMin = 1; latMax = 2;
    repeat (3) @(negedge clk);
    r0 = rowQ.size();
    pushAddr(10'd7, 20, ok); allOk = ok;
    pushAddr(10'd9, 20, ok); allOk &= ok;
    PLCPOL_AddrVld = 1'b0;
    waitRows(r0 + 2, 40, ok); allOk &= ok;
    bad = 0;
    if (!ok || rowQ[r0] !== rowOf(mapAddr(10'd7))) bad++;
    if (!ok || rowQ[r0+1] !== rowOf(mapAddr(10'd9))) bad++;
    assertCount++; if (!allOk || bad !== 0 || POLFETCH_Err !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_recover got %0d bad rows err=%b exp 0/0", bad, POLFETCH_Err); end
  endtask

  initial begin
    rst_n = 1'b0;
    PLCPOL_AddrVld = 1'b0;
    PLCPOL_Addr = '0;
`ifdef POL_FETCH_BASE_EN
    CfgBaseAddr = '0;
`endif
    repeat (3) @(negedge clk);
    $display("[TB] starting pol_fm_fetch tests");
    test_reset;
    test_streaming;
    test_backpressure;
    test_glb_stall;
    test_random;
`ifdef POL_FETCH_BASE_EN
    test_base;
`endif
    test_spurious;
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
